axicb_mcfifo: RTL and testbench
===============================

# axicb_mcfifo

Multi-channel single-clock FIFO that time-shares one simple dual-port RAM between `NB_CH` independent queues. Each channel owns a fixed region of `DEPTH` entries and keeps its own pointers and occupancy counter. One push and one pop are accepted per cycle, on any channels. It sits in the crossbar switching stages, where per-master or per-ID buffering must not cost one RAM per channel.

## Interface
- `NB_CH`, 4: number of channels; ≥1.
- `DEPTH`, 8: entries per channel; power of two, ≥2.
- `DATA_WIDTH`, 8: payload width.
- `AFULL_THRESH`, 6: `afull[ch]` asserts when the channel's level is ≥ this value; range 1..DEPTH.
- `CH_W`, derived: `$clog2(NB_CH)`, minimum 1. `PTR_W`, derived: `$clog2(DEPTH)`. `LVL_W`, derived: `PTR_W+1`.

- `aclk` in 1: clock; all logic on rising edge.
- `aresetn` in 1: asynchronous active-low reset.
- `flush` in NB_CH: synchronous per-channel clear.
- `push` in 1: write request.
- `push_ch` in CH_W: target channel of `push`.
- `data_in` in DATA_WIDTH: payload written on an accepted push.
- `pop` in 1: read request.
- `pop_ch` in CH_W: source channel of `pop`.
- `out_valid` out 1: `data_out` carries a popped entry.
- `out_ch` out CH_W: channel that `data_out` came from.
- `data_out` out DATA_WIDTH: popped payload.
- `empty` out NB_CH: per-channel empty.
- `full` out NB_CH: per-channel full.
- `afull` out NB_CH: per-channel almost-full.
- `level` out NB_CH*LVL_W: per-channel occupancy, packed with channel 0 in the LSBs.

## Operation
- RAM has `NB_CH*DEPTH` words. A physical address is `{ch, ptr}`. The RAM has no reset.
- Per channel: `wr_ptr` and `rd_ptr` of `PTR_W` bits, plus a `cnt` of `LVL_W` bits.
  - `empty = (cnt==0)`, `full = (cnt==DEPTH)`, `afull = (cnt>=AFULL_THRESH)`, `level = cnt`.
- Push is accepted when `push && !full[push_ch]`.
  - Writes `data_in` to `{push_ch, wr_ptr}`.
  - Increments `wr_ptr` modulo DEPTH; the pointer wraps naturally.
- Pop is accepted when `pop && !empty[pop_ch]`.
  - Reads `{pop_ch, rd_ptr}`.
  - Increments `rd_ptr` modulo DEPTH.
- Rejected requests leave all state unchanged. Overflow and underflow are silently dropped; there is no error flag.
- Push and pop on different channels in the same cycle are fully independent.
- Push and pop on the same channel in the same cycle:
  - `cnt` is unchanged; both pointers advance.
  - Acceptance is evaluated on the pre-cycle `cnt`. Push to a full channel is rejected even if that channel is also popped. Pop from an empty channel is rejected even if that channel is also pushed. There is no write-to-read bypass.
- Flush:
  - `flush[ch]` clears that channel's `wr_ptr`, `rd_ptr` and `cnt` at the next edge.
  - Flush overrides a same-cycle push or pop to that channel; those requests are discarded.
  - In the registered read mode, a pop accepted in the cycle before the flush still produces its `out_valid` beat.
  - Other channels are unaffected.
- `push_ch`/`pop_ch` ≥ NB_CH (non-power-of-two NB_CH): the request is rejected.

## Timing
- Reset values while `aresetn`=0:
  - all pointers and counters 0;
  - `empty` = all ones; `full`, `afull` = 0; `level` = 0;
  - `out_valid` = 0, `out_ch` = 0, `data_out` = 0.
- Status outputs (`empty`/`full`/`afull`/`level`) are registered-state derived. They reflect accepted operations one cycle after the request edge.
- Write-to-read latency: an entry pushed at edge N is poppable at the request evaluated after edge N, i.e. earliest pop in cycle N+1.
- Read latency is set by the configuration macro (see Configuration): 0 cycles without it, 1 cycle with it.
- Reset asserted mid-operation:
  - all queues become empty immediately;
  - an in-flight registered read is dropped (`out_valid` goes to 0 asynchronously).

## Configuration
- `AXICB_MCFIFO_FFD_EN`:
  - **Defined:** registered read. `out_valid`, `out_ch` and `data_out` are flops, updated one cycle after an accepted pop. `out_valid` is 0 in cycles following no accepted pop, and `data_out` holds its last value.
  - **Undefined:** combinational read. `out_valid = pop && !empty[pop_ch]`, `out_ch = pop_ch`, `data_out = ram[{pop_ch, rd_ptr[pop_ch]}]`, all in the same cycle. `data_out` is undefined when `out_valid`=0.

## Test plan
- Reset, then idle: `empty`=4'b1111, `full`=0, `level`=0, `out_valid`=0 for 10 cycles.
- Push 0x11..0x18 to channel 2 (DEPTH=8):
  - `afull[2]` rises after the 6th push; `full[2]` after the 8th;
  - a 9th push of 0xFF is rejected;
  - 8 pops return 0x11..0x18 in order, with `out_ch`=2;
  - a 9th pop gives `out_valid`=0.
- Interleave channels 0 and 3, then check that each channel pops only its own data in order:
  - push 0xA0 to ch0 and 0xB0 to ch3, alternating 5 times;
  - pop ch3 ×5 returns 0xB0..; pop ch0 ×5 returns 0xA0...
- Wrap and simultaneous push/pop on ch1:
  - hold `level[1]`=4, then push+pop ch1 every cycle for 20 cycles;
  - `level[1]` stays 4 and output order is preserved across pointer wrap.
- Boundary cases:
  - push ch0 while `full[0]` with a simultaneous pop ch0 → push rejected, level 8→7;
  - push ch1 while `empty[1]` with a simultaneous pop ch1 → pop rejected, level 0→1.
- Flush and reset:
  - flush ch2 at level 5 with a same-cycle push → `level[2]`=0 and `empty[2]`=1 next cycle; ch0 is untouched;
  - assert `aresetn`=0 mid-stream → all outputs return to reset values within the same cycle.
- Run the whole suite with and without `AXICB_MCFIFO_FFD_EN`, checking latency 1 vs 0 respectively.

Source files
------------

// File: rtl/axicb_mcfifo.sv
// Multi-channel single-clock FIFO: NB_CH queues share one simple dual-port RAM.
// Define AXICB_MCFIFO_FFD_EN for a registered (1-cycle) read port; default is combinational.
module axicb_mcfifo #(
  parameter int unsigned NB_CH        = 4,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned AFULL_THRESH = 6,
  localparam int unsigned CH_W  = (NB_CH > 1) ? $clog2(NB_CH) : 1,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NB_CH-1:0]        flush,
  input  logic                    push,
  input  logic [CH_W-1:0]         push_ch,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    pop,
  input  logic [CH_W-1:0]         pop_ch,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_ch,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [NB_CH-1:0]        empty,
  output logic [NB_CH-1:0]        full,
  output logic [NB_CH-1:0]        afull,
  output logic [NB_CH*LVL_W-1:0]  level
);

  localparam int unsigned ADDR_W   = CH_W + PTR_W;
  localparam int unsigned NB_WORDS = NB_CH * DEPTH;

  logic [DATA_WIDTH-1:0] mem [NB_WORDS];

  logic [PTR_W-1:0] wr_ptr [NB_CH];
  logic [PTR_W-1:0] rd_ptr [NB_CH];
  logic [LVL_W-1:0] cnt    [NB_CH];

  logic             push_hit, push_full, push_flush;
  logic             pop_hit, pop_empty, pop_flush;
  logic [PTR_W-1:0] wr_ptr_sel, rd_ptr_sel;
  logic             push_ok, pop_ok, push_acc, pop_acc;
  logic [NB_CH-1:0] wr_inc, rd_inc;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  // Status flags decoded from the per-channel occupancy counters
  always_comb begin
    empty = '0;
    full  = '0;
    afull = '0;
    level = '0;
    for (int ch = 0; ch < NB_CH; ch++) begin
      empty[ch] = (cnt[ch] == '0);
      full[ch]  = (cnt[ch] == LVL_W'(DEPTH));
      afull[ch] = (cnt[ch] >= LVL_W'(AFULL_THRESH));
      level[ch*LVL_W +: LVL_W] = cnt[ch];
    end
  end

  // Channel select by match loop so out-of-range channel numbers hit nothing
  always_comb begin
    push_hit   = 1'b0;
    push_full  = 1'b0;
    push_flush = 1'b0;
    pop_hit    = 1'b0;
    pop_empty  = 1'b0;
    pop_flush  = 1'b0;
    wr_ptr_sel = '0;
    rd_ptr_sel = '0;
    for (int ch = 0; ch < NB_CH; ch++) begin
      if (push_ch == CH_W'(ch)) begin
        push_hit   = 1'b1;
        push_full  = full[ch];
        push_flush = flush[ch];
        wr_ptr_sel = wr_ptr[ch];
      end
      if (pop_ch == CH_W'(ch)) begin
        pop_hit    = 1'b1;
        pop_empty  = empty[ch];
        pop_flush  = flush[ch];
        rd_ptr_sel = rd_ptr[ch];
      end
    end
  end

  assign push_ok  = push && push_hit && !push_full;
  assign pop_ok   = pop && pop_hit && !pop_empty;
  assign push_acc = push_ok && !push_flush;
  assign pop_acc  = pop_ok && !pop_flush;

  assign wr_addr = {push_ch, wr_ptr_sel};
  assign rd_addr = {pop_ch, rd_ptr_sel};

  always_comb begin
    wr_inc = '0;
    rd_inc = '0;
    for (int ch = 0; ch < NB_CH; ch++) begin
      wr_inc[ch] = push_acc && (push_ch == CH_W'(ch));
      rd_inc[ch] = pop_acc && (pop_ch == CH_W'(ch));
    end
  end

  // Shared storage; intentionally not reset
  always_ff @(posedge aclk) begin
    if (push_acc) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Per-channel pointers and occupancy; flush wins over same-cycle traffic
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int ch = 0; ch < NB_CH; ch++) begin
        wr_ptr[ch] <= '0;
        rd_ptr[ch] <= '0;
        cnt[ch]    <= '0;
      end
    end else begin
      for (int ch = 0; ch < NB_CH; ch++) begin
        if (flush[ch]) begin
          wr_ptr[ch] <= '0;
          rd_ptr[ch] <= '0;
          cnt[ch]    <= '0;
        end else begin
          if (wr_inc[ch]) begin
            wr_ptr[ch] <= wr_ptr[ch] + PTR_W'(1);
          end
          if (rd_inc[ch]) begin
            rd_ptr[ch] <= rd_ptr[ch] + PTR_W'(1);
          end
          if (wr_inc[ch] && !rd_inc[ch]) begin
            cnt[ch] <= cnt[ch] + LVL_W'(1);
          end else if (!wr_inc[ch] && rd_inc[ch]) begin
            cnt[ch] <= cnt[ch] - LVL_W'(1);
          end
        end
      end
    end
  end

`ifdef AXICB_MCFIFO_FFD_EN
  // Registered read port; data_out holds its value between pops
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      data_out  <= '0;
    end else begin
      out_valid <= pop_acc;
      if (pop_acc) begin
        out_ch   <= pop_ch;
        data_out <= mem[rd_addr];
      end
    end
  end
`else
  // Combinational read port, forced to zero while in reset
  always_comb begin
    out_valid = pop_ok && aresetn;
    out_ch    = aresetn ? pop_ch : '0;
    data_out  = aresetn ? mem[rd_addr] : '0;
  end
`endif

endmodule

// File: tb/tb_axicb_mcfifo.sv
// Directed bench for axicb_mcfifo with a per-channel reference model and an output scoreboard.
// Builds for either read mode depending on AXICB_MCFIFO_FFD_EN.
module tb_axicb_mcfifo;

  localparam int unsigned NB_CH = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned CH_W  = 2;
  localparam int unsigned LVL_W = 4;
  localparam int unsigned AFT   = 6;

  logic                   aclk = 1'b0;
  logic                   aresetn;
  logic [NB_CH-1:0]       flush;
  logic                   push;
  logic [CH_W-1:0]        push_ch;
  logic [DW-1:0]          data_in;
  logic                   pop;
  logic [CH_W-1:0]        pop_ch;
  logic                   out_valid;
  logic [CH_W-1:0]        out_ch;
  logic [DW-1:0]          data_out;
  logic [NB_CH-1:0]       empty;
  logic [NB_CH-1:0]       full;
  logic [NB_CH-1:0]       afull;
  logic [NB_CH*LVL_W-1:0] level;

  axicb_mcfifo #(
    .NB_CH(NB_CH), .DEPTH(DEPTH), .DATA_WIDTH(DW), .AFULL_THRESH(AFT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .flush(flush),
    .push(push), .push_ch(push_ch), .data_in(data_in),
    .pop(pop), .pop_ch(pop_ch),
    .out_valid(out_valid), .out_ch(out_ch), .data_out(data_out),
    .empty(empty), .full(full), .afull(afull), .level(level)
  );

  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0]      mq [NB_CH][$];
  logic [CH_W+DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    logic [NB_CH-1:0]       e, f, a;
    logic [NB_CH*LVL_W-1:0] l;
    e = '0; f = '0; a = '0; l = '0;
    for (int ch = 0; ch < NB_CH; ch++) begin
      e[ch] = (mq[ch].size() == 0);
      f[ch] = (mq[ch].size() == DEPTH);
      a[ch] = (mq[ch].size() >= AFT);
      l[ch*LVL_W +: LVL_W] = LVL_W'(mq[ch].size());
    end
    chk({tag, ":empty"}, 32'(empty), 32'(e));
    chk({tag, ":full"},  32'(full),  32'(f));
    chk({tag, ":afull"}, 32'(afull), 32'(a));
    chk({tag, ":level"}, 32'(level), 32'(l));
  endtask

  task automatic chk_out(input string tag, input logic exp_v);
    logic [CH_W+DW-1:0] ent;
    chk({tag, ":out_valid"}, 32'(out_valid), 32'(exp_v));
    if (exp_v && exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      chk({tag, ":data_out"}, 32'(data_out), 32'(ent[DW-1:0]));
      chk({tag, ":out_ch"},   32'(out_ch),   32'(ent[CH_W+DW-1:DW]));
    end
  endtask

  // One clock of stimulus; the model is advanced after the DUT edge
  task automatic step(input logic ps, input logic [CH_W-1:0] pc, input logic [DW-1:0] d,
                      input logic pp, input logic [CH_W-1:0] ppc, input logic [NB_CH-1:0] fl,
                      input string tag);
    logic exp_v, push_v, pop_v;
    @(negedge aclk);
    push = ps; push_ch = pc; data_in = d;
    pop = pp; pop_ch = ppc; flush = fl;
    push_v = ps && (mq[pc].size() < DEPTH) && !fl[pc];
    pop_v  = pp && (mq[ppc].size() > 0) && !fl[ppc];
`ifdef AXICB_MCFIFO_FFD_EN
    exp_v = pop_v;
`else
    exp_v = pp && (mq[ppc].size() > 0);
`endif
    if (exp_v) exp_q.push_back({ppc, mq[ppc][0]});
    #1;
`ifndef AXICB_MCFIFO_FFD_EN
    chk_out(tag, exp_v);
`endif
    @(posedge aclk);
    #1;
`ifdef AXICB_MCFIFO_FFD_EN
    chk_out(tag, exp_v);
`endif
    for (int ch = 0; ch < NB_CH; ch++) if (fl[ch]) mq[ch].delete();
    if (pop_v)  void'(mq[ppc].pop_front());
    if (push_v) mq[pc].push_back(d);
    chk_status(tag);
  endtask

  task automatic do_push(input logic [CH_W-1:0] c, input logic [DW-1:0] d, input string tag);
    step(1'b1, c, d, 1'b0, '0, '0, tag);
  endtask

  task automatic do_pop(input logic [CH_W-1:0] c, input string tag);
    step(1'b0, '0, '0, 1'b1, c, '0, tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ":empty"},     32'(empty),     32'hF);
    chk({tag, ":full"},      32'(full),      32'h0);
    chk({tag, ":afull"},     32'(afull),     32'h0);
    chk({tag, ":level"},     32'(level),     32'h0);
    chk({tag, ":out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, ":out_ch"},    32'(out_ch),    32'h0);
    chk({tag, ":data_out"},  32'(data_out),  32'h0);
  endtask

  initial begin
    aresetn = 1'b0; flush = '0; push = 1'b0; push_ch = '0; data_in = '0;
    pop = 1'b0; pop_ch = '0;
    #12;
    chk_reset_vals("reset");
    @(negedge aclk);
    aresetn = 1'b1;

    for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b0, '0, '0, "idle");

    // Fill ch2 to full, overflow, then drain and underflow
    for (int i = 0; i < 8; i++) begin
      do_push(2'd2, 8'(8'h11 + i), "fill2");
      if (i == 4) chk("afull2_at5", 32'(afull[2]), 32'h0);
      if (i == 5) chk("afull2_at6", 32'(afull[2]), 32'h1);
      if (i == 6) chk("full2_at7",  32'(full[2]),  32'h0);
    end
    chk("full2_at8", 32'(full[2]), 32'h1);
    do_push(2'd2, 8'hFF, "ovf2");
    chk("lvl2_ovf", 32'(level[2*LVL_W +: LVL_W]), 32'd8);
    for (int i = 0; i < 8; i++) do_pop(2'd2, "drain2");
    do_pop(2'd2, "udf2");

    // Interleaved channels 0 and 3
    for (int i = 0; i < 5; i++) begin
      do_push(2'd0, 8'(8'hA0 + i), "il_push0");
      do_push(2'd3, 8'(8'hB0 + i), "il_push3");
    end
    for (int i = 0; i < 5; i++) do_pop(2'd3, "il_pop3");
    for (int i = 0; i < 5; i++) do_pop(2'd0, "il_pop0");

    // Steady push+pop on ch1 across pointer wrap
    for (int i = 0; i < 4; i++) do_push(2'd1, 8'(8'h40 + i), "pre1");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'd1, 8'(8'h50 + i), 1'b1, 2'd1, '0, "pp1");
      chk("lvl1_hold", 32'(level[1*LVL_W +: LVL_W]), 32'd4);
    end
    for (int i = 0; i < 4; i++) do_pop(2'd1, "post1");

    // Same-channel push+pop at full and at empty
    for (int i = 0; i < 8; i++) do_push(2'd0, 8'(8'hC0 + i), "fill0");
    step(1'b1, 2'd0, 8'hEE, 1'b1, 2'd0, '0, "full0_pp");
    chk("lvl0_full_pp", 32'(level[0*LVL_W +: LVL_W]), 32'd7);
    step(1'b1, 2'd1, 8'h77, 1'b1, 2'd1, '0, "empty1_pp");
    chk("lvl1_empty_pp", 32'(level[1*LVL_W +: LVL_W]), 32'd1);

    // Flush ch2 with a same-cycle push; ch0 must be untouched
    for (int i = 0; i < 5; i++) do_push(2'd2, 8'(8'h20 + i), "fill2b");
    step(1'b1, 2'd2, 8'h99, 1'b0, '0, 4'b0100, "flush2");
    chk("lvl2_flush", 32'(level[2*LVL_W +: LVL_W]), 32'd0);
    chk("empty2_flush", 32'(empty[2]), 32'h1);
    chk("lvl0_flush", 32'(level[0*LVL_W +: LVL_W]), 32'd7);
    do_pop(2'd0, "pop0_after_flush");
    do_pop(2'd1, "pop1_after_flush");

    // Asynchronous reset in the middle of a pop cycle
    do_pop(2'd0, "pop0_pre_reset");
    pop = 1'b1; pop_ch = 2'd0;
    #1;
    aresetn = 1'b0;
    #1;
    chk_reset_vals("midreset");
    for (int ch = 0; ch < NB_CH; ch++) mq[ch].delete();
    exp_q.delete();
    @(negedge aclk);
    aresetn = 1'b1;
    pop = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, '0, '0, "post_reset");
    do_push(2'd3, 8'h5A, "post_reset_push");
    do_pop(2'd3, "post_reset_pop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
